csr_access_unit: RTL and testbench

Executes the six Zicsr instructions (CSRRW, CSRRS, CSRRC and their immediate forms) for the control section. It sits directly upstream of the CSR register file. It takes decoded CSR operations from decode and drives the register file's read port. It then performs the read-modify-write, issues a single full-word write-back, and returns the old CSR value for rd to the writeback stage over a valid/ready handshake.

---
 rtl/csr_access_unit.sv | 174 +++++++++++++++++
 tb/tb_csr_access_unit.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
// Zicsr execute unit: read-modify-write of one CSR per instruction, old value returned for rd.
// Optional illegal-instruction detection is enabled with `define CSR_ACCESS_ILLEGAL_EN.
module csr_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [2:0]  funct3,
    input  logic [11:0] csr_addr,
    input  logic [4:0]  rs1_idx,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  rd_idx,
    output logic        csr_read,
    output logic [11:0] csr_read_address,
    input  logic [31:0] csr_read_data,
    output logic [1:0]  csr_write_back,
    output logic [11:0] csr_write_back_address,
    output logic [31:0] csr_write_back_data,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [4:0]  result_rd,
    output logic [31:0] result_data,
    output logic        result_illegal
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRead = 2'd1;
    localparam logic [1:0] StExec = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    // funct3[1:0] selects the operation; funct3[2] selects the immediate operand.
    localparam logic [1:0] OpNone  = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpSet   = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    logic [1:0]  state_q, state_d;
    logic [1:0]  op_q;
    logic [31:0] operand_q;
    logic [11:0] addr_q;
    logic [4:0]  rd_q;
    logic        do_read_q;
    logic        do_write_q;

    logic [1:0]  wb_cmd_q;
    logic [11:0] wb_addr_q;
    logic [31:0] wb_data_q;
    logic        res_valid_q;
    logic [4:0]  res_rd_q;
    logic [31:0] res_data_q;
    logic        res_illegal_q;

    logic [1:0]  dec_op;
    logic [31:0] dec_operand;
    logic        dec_read;
    logic        dec_write;
    logic        dec_illegal;
    logic        accept;
    logic [31:0] old_val;
    logic [31:0] new_val;

    always_comb begin
        dec_op      = funct3[1:0];
        dec_operand = funct3[2] ? {27'b0, rs1_idx} : rs1_data;
        dec_read    = !((dec_op == OpWrite) && (rd_idx == 5'd0));
        dec_write   = (dec_op == OpWrite) || ((dec_op != OpNone) && (rs1_idx != 5'd0));
`ifdef CSR_ACCESS_ILLEGAL_EN
        dec_illegal = (dec_op == OpNone) || (dec_write && (csr_addr[11:10] == 2'b11));
`else
        dec_illegal = 1'b0;
`endif
        accept      = instr_valid && (state_q == StIdle);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (dec_illegal) begin
                        state_d = StResp;
                    end else if (dec_read) begin
                        state_d = StRead;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StRead:  state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (result_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Suppressed reads behave as if the CSR held zero.
    always_comb begin
        old_val = do_read_q ? csr_read_data : 32'd0;
        unique case (op_q)
            OpWrite: new_val = operand_q;
            OpSet:   new_val = old_val | operand_q;
            OpClear: new_val = old_val & ~operand_q;
            default: new_val = old_val;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            op_q          <= OpNone;
            operand_q     <= 32'd0;
            addr_q        <= 12'd0;
            rd_q          <= 5'd0;
            do_read_q     <= 1'b0;
            do_write_q    <= 1'b0;
            wb_cmd_q      <= 2'b00;
            wb_addr_q     <= 12'd0;
            wb_data_q     <= 32'd0;
            res_valid_q   <= 1'b0;
            res_rd_q      <= 5'd0;
            res_data_q    <= 32'd0;
            res_illegal_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            // Write-back is a one-cycle pulse regardless of result backpressure.
            wb_cmd_q <= 2'b00;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q       <= dec_op;
                        operand_q  <= dec_operand;
                        addr_q     <= csr_addr;
                        rd_q       <= rd_idx;
                        do_read_q  <= dec_read && !dec_illegal;
                        do_write_q <= dec_write && !dec_illegal;
                        if (dec_illegal) begin
                            res_valid_q   <= 1'b1;
                            res_rd_q      <= rd_idx;
                            res_data_q    <= 32'd0;
                            res_illegal_q <= 1'b1;
                        end
                    end
                end
                StExec: begin
                    res_valid_q   <= 1'b1;
                    res_rd_q      <= rd_q;
                    res_data_q    <= old_val;
                    res_illegal_q <= 1'b0;
                    wb_addr_q     <= addr_q;
                    wb_data_q     <= new_val;
                    if (do_write_q) wb_cmd_q <= 2'b11;
                end
                StResp: begin
                    if (result_ready) res_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        instr_ready            = !rst && (state_q == StIdle);
        csr_read               = !rst && (state_q == StRead);
        csr_read_address       = rst ? 12'd0 : addr_q;
        csr_write_back         = rst ? 2'b00 : wb_cmd_q;
        csr_write_back_address = rst ? 12'd0 : wb_addr_q;
        csr_write_back_data    = rst ? 32'd0 : wb_data_q;
        result_valid           = !rst && res_valid_q;
        result_rd              = rst ? 5'd0 : res_rd_q;
        result_data            = rst ? 32'd0 : res_data_q;
        result_illegal         = !rst && res_illegal_q;
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Scoreboard bench for csr_access_unit with a behavioural CSR register file.
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [4:0]  rs1_idx;
    logic [31:0] rs1_data;
    logic [4:0]  rd_idx;
    logic        csr_read;
    logic [11:0] csr_read_address;
    logic [31:0] csr_read_data;
    logic [1:0]  csr_write_back;
    logic [11:0] csr_write_back_address;
    logic [31:0] csr_write_back_data;
    logic        result_valid;
    logic        result_ready;
    logic [4:0]  result_rd;
    logic [31:0] result_data;
    logic        result_illegal;

    csr_access_unit dut (
        .clk                    (clk),
        .rst                    (rst),
        .instr_valid            (instr_valid),
        .instr_ready            (instr_ready),
        .funct3                 (funct3),
        .csr_addr               (csr_addr),
        .rs1_idx                (rs1_idx),
        .rs1_data               (rs1_data),
        .rd_idx                 (rd_idx),
        .csr_read               (csr_read),
        .csr_read_address       (csr_read_address),
        .csr_read_data          (csr_read_data),
        .csr_write_back         (csr_write_back),
        .csr_write_back_address (csr_write_back_address),
        .csr_write_back_data    (csr_write_back_data),
        .result_valid           (result_valid),
        .result_ready           (result_ready),
        .result_rd              (result_rd),
        .result_data            (result_data),
        .result_illegal         (result_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ill;
    } res_t;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    res_t exp_res[$];
    wr_t  exp_wr[$];

    int n_checks = 0;
    int n_errors = 0;
    int wb_count = 0;

    logic [31:0] rf      [0:4095];
    logic [31:0] ref_csr [0:4095];
    logic        preload;

    function automatic logic [31:0] init_val(input int a);
        logic [11:0] a12;
        a12 = a[11:0];
        case (a12)
            12'hC01: return 32'h0000_1234;
            12'hC03: return 32'hFFFF_00FF;
            12'hC04: return 32'h0000_0000;
            12'hC05: return 32'h0000_0055;
            default: return {a12, 8'h00, a12};
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Register-file environment: registered read data, write on command 11.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++) rf[i] <= init_val(i);
            csr_read_data <= 32'd0;
        end else begin
            if (csr_read) csr_read_data <= rf[csr_read_address];
            if (csr_write_back == 2'b11) rf[csr_write_back_address] <= csr_write_back_data;
        end
    end

    // Monitor: compares write-backs and accepted results against the scoreboard.
    always @(negedge clk) begin
        res_t r;
        wr_t  w;
        if (csr_write_back != 2'b00) begin
            wb_count++;
            check_eq("wb_code", csr_write_back, 2'b11);
            if (exp_wr.size() == 0) begin
                check_eq("wb_unexpected", 1, 0);
            end else begin
                w = exp_wr.pop_front();
                check_eq("wb_addr", csr_write_back_address, w.addr);
                check_eq("wb_data", csr_write_back_data, w.data);
            end
        end
        if (result_valid && result_ready) begin
            if (exp_res.size() == 0) begin
                check_eq("res_unexpected", 1, 0);
            end else begin
                r = exp_res.pop_front();
                check_eq("res_rd", result_rd, r.rd);
                check_eq("res_data", result_data, r.data);
                check_eq("res_illegal", result_illegal, r.ill);
            end
        end
    end

    task automatic run_op(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                          input logic [31:0] rs1d, input logic [4:0] rd, input int stall);
        logic [1:0]  op;
        logic [31:0] operand, old, nv;
        bit          do_read, do_write, ill, ok, seen;
        int          lat, cyc, reads, wb0;
        res_t        r;
        wr_t         w;

        op       = f3[1:0];
        operand  = f3[2] ? {27'b0, rs1} : rs1d;
        do_read  = !(op == 2'b01 && rd == 5'd0);
        do_write = (op == 2'b01) || (op != 2'b00 && rs1 != 5'd0);
        ill      = 1'b0;
`ifdef CSR_ACCESS_ILLEGAL_EN
        ill = (op == 2'b00) || (do_write && addr[11:10] == 2'b11);
`endif
        if (ill) begin
            do_read  = 1'b0;
            do_write = 1'b0;
        end
        old = do_read ? ref_csr[addr] : 32'd0;
        case (op)
            2'b01:   nv = operand;
            2'b10:   nv = old | operand;
            2'b11:   nv = old & ~operand;
            default: nv = old;
        endcase
        r.rd   = rd;
        r.data = ill ? 32'd0 : old;
        r.ill  = ill;
        exp_res.push_back(r);
        if (do_write) begin
            w.addr = addr;
            w.data = nv;
            exp_wr.push_back(w);
            ref_csr[addr] = nv;
        end
        lat = ill ? 1 : (do_read ? 3 : 2);
        wb0 = wb_count;

        @(posedge clk); #1;
        instr_valid  = 1'b1;
        funct3       = f3;
        csr_addr     = addr;
        rs1_idx      = rs1;
        rs1_data     = rs1d;
        rd_idx       = rd;
        result_ready = (stall == 0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check_eq("accept_timeout", 0, 1);
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // Scramble inputs after accept so only latched values can matter.
        instr_valid = 1'b0;
        funct3      = 3'($urandom);
        csr_addr    = 12'($urandom);
        rs1_idx     = 5'($urandom);
        rs1_data    = $urandom;
        rd_idx      = 5'($urandom);

        cyc   = 0;
        reads = 0;
        seen  = 1'b0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (csr_read) begin
                reads++;
                check_eq("read_cycle", cyc, 1);
                check_eq("read_addr", csr_read_address, addr);
            end
            if (result_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("latency", seen ? cyc : 99, lat);
        check_eq("wb_first", csr_write_back, do_write ? 2'b11 : 2'b00);
        check_eq("read_count", reads, do_read ? 1 : 0);
        if (stall > 0) begin
            for (int i = 1; i < stall; i++) begin
                @(negedge clk);
                check_eq("valid_hold", result_valid, 1);
            end
            @(posedge clk); #1;
            result_ready = 1'b1;
        end
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("ready_after_hs", instr_ready, 1);
        check_eq("valid_after_hs", result_valid, 0);
        check_eq("wb_pulses", wb_count - wb0, do_write ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] addrs [0:3];
        int          wb0;
        bit          ok;

        addrs[0] = 12'h300;
        addrs[1] = 12'h301;
        addrs[2] = 12'hC10;
        addrs[3] = 12'h302;
        for (int i = 0; i < 4096; i++) ref_csr[i] = init_val(i);

        rst          = 1'b1;
        preload      = 1'b1;
        instr_valid  = 1'b0;
        funct3       = 3'd0;
        csr_addr     = 12'd0;
        rs1_idx      = 5'd0;
        rs1_data     = 32'd0;
        rd_idx       = 5'd0;
        result_ready = 1'b1;

        @(negedge clk);
        check_eq("rst_ready", instr_ready, 0);
        check_eq("rst_valid", result_valid, 0);
        check_eq("rst_read", csr_read, 0);
        check_eq("rst_wb", csr_write_back, 0);
        @(posedge clk); #1;
        rst     = 1'b0;
        preload = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", instr_ready, 1);
        check_eq("post_rst_data", result_data, 0);
        check_eq("post_rst_illegal", result_illegal, 0);

        run_op(3'b010, 12'hC01, 5'd0, 32'h0000_DEAD, 5'd5, 0);   // CSRRS, no write
        run_op(3'b101, 12'hC02, 5'd7, 32'h0, 5'd0, 0);           // CSRRWI, no read
        run_op(3'b011, 12'hC03, 5'd2, 32'h0000_000F, 5'd4, 5);   // CSRRC with backpressure
        run_op(3'b010, 12'hC04, 5'd1, 32'h0000_0001, 5'd1, 0);   // CSRRS then dependent CSRRS
        run_op(3'b010, 12'hC04, 5'd1, 32'h0000_0002, 5'd1, 0);
        run_op(3'b001, 12'hC04, 5'd3, 32'h0000_0000, 5'd2, 0);   // read back final 0x3
        run_op(3'b110, 12'h300, 5'd9, 32'h0, 5'd6, 1);           // CSRRSI
        run_op(3'b111, 12'h300, 5'd1, 32'h0, 5'd6, 0);           // CSRRCI
        run_op(3'b001, 12'hC00, 5'd3, 32'h1357_9BDF, 5'd3, 0);   // RW to read-only address
        run_op(3'b100, 12'h301, 5'd4, 32'h0000_00FF, 5'd8, 0);   // reserved funct3

        // Reset in the EXEC cycle of a CSRRW must abandon the op entirely.
        wb0 = wb_count;
        @(posedge clk); #1;
        instr_valid = 1'b1;
        funct3      = 3'b001;
        csr_addr    = 12'hC05;
        rs1_idx     = 5'd6;
        rs1_data    = 32'h0000_ABCD;
        rd_idx      = 5'd2;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("rst_op_accept", ok, 1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_wb", csr_write_back, 0);
        check_eq("midrst_valid", result_valid, 0);
        check_eq("midrst_ready", instr_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_ready_after", instr_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("midrst_no_result", result_valid, 0);
        end
        check_eq("midrst_no_wb", wb_count - wb0, 0);
        run_op(3'b010, 12'hC05, 5'd0, 32'h0, 5'd1, 0);           // must still read 0x55

        for (int n = 0; n < 30; n++) begin
            run_op(3'($urandom_range(0, 7)), addrs[$urandom_range(0, 3)],
                   5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 2)),
                   $urandom_range(0, 2));
        end

        repeat (3) @(negedge clk);
        check_eq("final_c04", rf[12'hC04], ref_csr[12'hC04]);
        for (int i = 0; i < 4; i++) check_eq("final_csr", rf[addrs[i]], ref_csr[addrs[i]]);
        check_eq("res_queue_empty", exp_res.size(), 0);
        check_eq("wr_queue_empty", exp_wr.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
